uart_sample_loader: RTL and testbench
=====================================

# uart_sample_loader

Receives FFT input samples over the UART RX line and writes them word-by-word into the sample RAM that feeds the FFT controller, replacing the fixed test ROM with host-loaded data. A load frame is a command byte `SIG_LOAD` followed by `DATA_LENGTH` complex samples, each serialized as little-endian bytes. The block sits between the board RX pin and the write port of the sample RAM; the FFT controller reads the RAM through its existing address/data port.

## Interface
- `CLKS_PER_BIT`, 434 — clocks per UART bit (50 MHz / 115200).
- `SIG_LOAD`, 76 — command byte (`'L'`) that opens a load frame.
- `DATA_LENGTH`, 256 — complex samples per frame.
- `length`, 32 — bits per real/imag component; `2*length` must be a multiple of 8.
- `TIMEOUT_CLKS`, 50000 — maximum idle gap between data bytes inside a frame.
- `i_clk` input 1 — system clock.
- `i_rst` input 1 — reset, synchronous, active-high.
- `i_rxd` input 1 — UART serial in; idles high.
- `o_wr_en` output 1 — one-cycle RAM write strobe.
- `o_wr_addr` output 10 — RAM write address.
- `o_wr_data` output 2*length — `{imag, real}`; real occupies `[length-1:0]`.
- `o_busy` output 1 — high while a frame is in progress.
- `o_load_done` output 1 — one-cycle pulse after the last word is written.
- `o_frame_err` output 1 — one-cycle pulse when a frame is aborted.

## Operation
- RX front end:
  - `i_rxd` passes through a 2-flop synchronizer (reset value 1).
  - Start is a detected falling edge. The start bit is re-sampled at `CLKS_PER_BIT/2`; if it is high again, treat it as a glitch and return to idle.
  - Data: 8 bits, LSB first, sampled every `CLKS_PER_BIT`.
  - Stop bit is sampled at the next bit centre.
  - At the stop sample, emit a byte-valid pulse plus a stop-ok flag.
- Loader FSM:
  - IDLE:
    - Discard every byte except `SIG_LOAD`.
    - On `SIG_LOAD` with stop-ok: clear the address, byte index and shift register, then go to RECV.
  - RECV:
    - Each valid byte is written into bits `[8*idx+7 : 8*idx]` of the word register, where `idx` runs 0 to `2*length/8 - 1`.
    - When the last byte of a word arrives, go to WRITE.
  - WRITE:
    - Assert `o_wr_en` for exactly one cycle with the current address and word.
    - Then increment the address.
    - If the written address was `DATA_LENGTH-1`, go to DONE; otherwise return to RECV.
  - DONE: pulse `o_load_done` for one cycle, then go to IDLE.
- Stop-bit error:
  - Outside a frame (in IDLE): drop the byte, no error pulse.
  - Inside a frame (RECV): pulse `o_frame_err`, go to IDLE. RAM contents already written are left as-is.
- Inside RECV, `SIG_LOAD` is ordinary data; the frame cannot be restarted mid-frame.
- The address never wraps within a frame. A new frame always starts at 0.

## Timing
- Reset:
  - All outputs are 0; FSM is in IDLE; synchronizer is 1.
  - Reset mid-byte or mid-frame abandons the frame immediately and writes nothing.
- Byte latency: byte-valid is asserted 2 sync cycles + 9.5 bit-times after the start edge.
- Write latency: `o_wr_en` is high the cycle after the byte-valid of a word's last byte.
- `o_wr_addr` and `o_wr_data` are stable while `o_wr_en` is high.
- `o_load_done` is high the cycle after the final `o_wr_en`.
- `o_busy`:
  - Rises the cycle after `SIG_LOAD` is accepted.
  - Falls in the same cycle that `o_load_done` or `o_frame_err` pulses.
- Back-to-back frames are legal. The next `SIG_LOAD` byte is accepted once the FSM is in IDLE, which is always true before the next byte can complete.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - A gap counter runs in RECV. It is cleared on each byte-valid and on entering RECV.
  - When it reaches `TIMEOUT_CLKS`: pulse `o_frame_err`, go to IDLE.
  - The counter holds at 0 outside RECV.
- `LOADER_TIMEOUT_EN` undefined:
  - No counter is built and `TIMEOUT_CLKS` is ignored.
  - A stalled frame waits indefinitely, until reset or a stop-bit error.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, RECV, WRITE, DONE).
  - The `SIG_LOAD` default.
  - The derived constant `BYTES_PER_WORD = 2*length/8`.
- One sub-module: `uart_rx_byte` (synchronizer, bit timing, byte-valid/stop-ok). The frame FSM lives in `uart_sample_loader`.

## Test plan
All scenarios use `CLKS_PER_BIT=8`, `DATA_LENGTH=4`, `length=32`.
- Load: send `0x4C` then 32 bytes `0x00..0x1F` -> 4 writes:
  - addr 0 data `0x0706050403020100`;
  - addr 3 data `0x1F1E1D1C1B1A1918`;
  - `o_load_done` 1 cycle after the 4th write;
  - `o_busy` spans the frame.
- Bytes before the command: send `0x41`, `0x00`, then a full frame -> no writes before `0x4C`; the frame then loads normally from addr 0.
- Stop-bit error: stop bit driven low on byte 10 of a frame -> `o_frame_err` pulse, exactly 1 write (addr 0) done, FSM in IDLE, next frame starts at addr 0.
- Glitch: a 2-cycle low pulse on `i_rxd` in IDLE -> no byte produced, no outputs change.
- Reset mid-frame: `i_rst` asserted after 5 data bytes -> all outputs 0; then a full frame writes addr 0..3 correctly.
- Timeout (`LOADER_TIMEOUT_EN` defined, `TIMEOUT_CLKS=200`): stall 300 cycles after byte 3 -> `o_frame_err` at gap cycle 200, no writes. With the macro undefined, the same stall produces no error.

Source files
------------

// File: rtl/uart_sample_loader_pkg.sv
// Shared types and constants for the UART sample loader: loader FSM encoding,
// default load command byte and bytes-per-word derivation.
package uart_sample_loader_pkg;

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} load_state_e;

  localparam logic [7:0]  SIG_LOAD_DEFAULT = 8'd76;
  localparam int unsigned LENGTH_DEFAULT   = 32;
  localparam int unsigned BYTES_PER_WORD   = 2 * LENGTH_DEFAULT / 8;

  function automatic int unsigned bytes_per_word(input int unsigned len);
    return 2 * len / 8;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, falling-edge start detect with
// mid-bit glitch rejection, 8N1 sampling, byte-valid pulse with stop-ok flag.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_stop_ok
);

  localparam int unsigned    CntW     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       state_q;
  logic            rx_meta, rx_sync, rx_prev;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_stop_ok <= 1'b0;
    end else begin
      rx_meta <= i_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      o_valid <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          if (rx_prev && !rx_sync) begin
            state_q <= RxStart;
            cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state_q   <= rx_sync ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= RxStop;
            else bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            state_q   <= RxIdle;
            o_valid   <= 1'b1;
            o_data    <= shift_q;
            o_stop_ok <= rx_sync;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_sample_loader.sv
// Loads complex FFT samples received over UART into the sample RAM write port.
// Define LOADER_TIMEOUT_EN to abort frames whose inter-byte gap reaches TIMEOUT_CLKS.
module uart_sample_loader
  import uart_sample_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SIG_LOAD     = SIG_LOAD_DEFAULT,
  parameter int unsigned DATA_LENGTH  = 256,
  parameter int unsigned length       = LENGTH_DEFAULT,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rxd,
  output logic                o_wr_en,
  output logic [9:0]          o_wr_addr,
  output logic [2*length-1:0] o_wr_data,
  output logic                o_busy,
  output logic                o_load_done,
  output logic                o_frame_err
);

  localparam int unsigned     Bpw      = bytes_per_word(length);
  localparam int unsigned     IdxW     = (Bpw > 1) ? $clog2(Bpw) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(Bpw - 1);
  localparam logic [9:0]      LastAddr = 10'(DATA_LENGTH - 1);

  logic       rx_valid, rx_stop_ok;
  logic [7:0] rx_data;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_rxd    (i_rxd),
    .o_valid  (rx_valid),
    .o_data   (rx_data),
    .o_stop_ok(rx_stop_ok)
  );

  load_state_e         state_q;
  logic [9:0]          addr_q;
  logic [IdxW-1:0]     byte_idx_q;
  logic [2*length-1:0] word_q, word_ins;
  logic                timeout;

  always_comb begin
    word_ins = word_q;
    word_ins[byte_idx_q*8 +: 8] = rx_data;
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned GapW = $clog2(TIMEOUT_CLKS + 1);
  logic [GapW-1:0] gap_q;

  assign timeout = (state_q == StRecv) && !rx_valid && (gap_q == GapW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != StRecv || rx_valid) gap_q <= '0;
    else gap_q <= gap_q + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CLKS;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_busy      <= 1'b0;
      o_load_done <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_wr_en     <= 1'b0;
      o_load_done <= 1'b0;
      o_frame_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid && rx_stop_ok && rx_data == SIG_LOAD) begin
            addr_q     <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            o_busy     <= 1'b1;
            state_q    <= StRecv;
          end
        end
        StRecv: begin
          if (rx_valid) begin
            if (!rx_stop_ok) begin
              o_frame_err <= 1'b1;
              o_busy      <= 1'b0;
              state_q     <= StIdle;
            end else if (byte_idx_q == LastIdx) begin
              // Strobe issued here so the write lands the cycle after the last byte.
              byte_idx_q <= '0;
              word_q     <= word_ins;
              o_wr_en    <= 1'b1;
              o_wr_addr  <= addr_q;
              o_wr_data  <= word_ins;
              state_q    <= StWrite;
            end else begin
              word_q     <= word_ins;
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end else if (timeout) begin
            o_frame_err <= 1'b1;
            o_busy      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StWrite: begin
          addr_q <= addr_q + 10'd1;
          if (addr_q == LastAddr) begin
            o_load_done <= 1'b1;
            o_busy      <= 1'b0;
            state_q     <= StDone;
          end else begin
            state_q <= StRecv;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sample_loader.sv
// Self-checking bench for uart_sample_loader: random frames over a modelled UART
// line, expected RAM words computed from the frame byte stream.
module tb_uart_sample_loader;

  localparam int unsigned Cpb        = 8;
  localparam int unsigned DataLen    = 4;
  localparam int unsigned Bpw        = 8;
  localparam int unsigned FrameBytes = DataLen * Bpw;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        wr_en, busy, load_done, frame_err;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;

  always #5 clk = ~clk;

  uart_sample_loader #(
    .CLKS_PER_BIT(Cpb),
    .SIG_LOAD    (8'h4C),
    .DATA_LENGTH (DataLen),
    .length      (32),
    .TIMEOUT_CLKS(200)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rxd      (rxd),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_busy     (busy),
    .o_load_done(load_done),
    .o_frame_err(frame_err)
  );

  typedef struct {logic [9:0] addr; logic [63:0] data; int cyc;} wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_overlap = 0;
  int   activity = 0;
  wr_t  wr_log[$];
  int   done_log[$];
  int   err_log[$];
  logic busy_after_cmd;

  logic [7:0]  fbytes[FrameBytes];
  logic [63:0] exp_words[DataLen];

  always @(negedge clk) begin
    cyc++;
    if (wr_en) wr_log.push_back('{addr: wr_addr, data: wr_data, cyc: cyc});
    if (load_done) begin
      done_log.push_back(cyc);
      if (busy) busy_overlap++;
    end
    if (frame_err) begin
      err_log.push_back(cyc);
      if (busy) busy_overlap++;
    end
    if (wr_en | busy | load_done | frame_err) activity++;
  end

  // Reference: word k gathers bytes 8k..8k+7 little-endian.
  task automatic build_model();
    for (int w = 0; w < DataLen; w++) begin
      exp_words[w] = '0;
      for (int i = 0; i < Bpw; i++) exp_words[w] |= 64'(fbytes[w*Bpw+i]) << (8 * i);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < FrameBytes; i++) fbytes[i] = 8'($urandom);
    build_model();
  endtask

  task automatic clear_logs();
    wr_log.delete();
    done_log.delete();
    err_log.delete();
    busy_overlap = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rxd = stop;
    repeat (Cpb) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame();
    send_byte(8'h4C, 1'b1);
    busy_after_cmd = busy;
    for (int i = 0; i < FrameBytes; i++) send_byte(fbytes[i], 1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 64'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_load();
    clear_logs();
    for (int i = 0; i < FrameBytes; i++) fbytes[i] = 8'(i);
    build_model();
    send_frame();
    checks++; if (busy_after_cmd !== 1'b1) begin errors++; $display("FAIL load_busy_mid: got %b want 1", busy_after_cmd); end
    checks++; if (wr_log.size() !== DataLen) begin errors++; $display("FAIL load_wr_count: got %0d want %0d", wr_log.size(), DataLen); end
    for (int k = 0; k < DataLen && k < wr_log.size(); k++) begin
      checks++;
      if (wr_log[k].addr !== 10'(k) || wr_log[k].data !== exp_words[k]) begin
        errors++;
        $display("FAIL load_word%0d: got addr %0d data %h want addr %0d data %h", k, wr_log[k].addr, wr_log[k].data, k, exp_words[k]);
      end
    end
    if (wr_log.size() == DataLen) begin
      checks++; if (wr_log[0].data !== 64'h0706050403020100) begin errors++; $display("FAIL load_addr0: got %h want 0706050403020100", wr_log[0].data); end
      checks++; if (wr_log[3].data !== 64'h1F1E1D1C1B1A1918) begin errors++; $display("FAIL load_addr3: got %h want 1f1e1d1c1b1a1918", wr_log[3].data); end
    end
    checks++; if (done_log.size() !== 1) begin errors++; $display("FAIL load_done_count: got %0d want 1", done_log.size()); end
    if (done_log.size() == 1 && wr_log.size() > 0) begin
      checks++;
      if (done_log[0] !== wr_log[wr_log.size()-1].cyc + 1) begin
        errors++; $display("FAIL load_done_timing: got cycle %0d want %0d", done_log[0], wr_log[wr_log.size()-1].cyc + 1);
      end
    end
    checks++; if (busy !== 1'b0 || busy_overlap !== 0) begin errors++; $display("FAIL load_busy_end: got busy %b overlap %0d want 0 0", busy, busy_overlap); end
    checks++; if (err_log.size() !== 0) begin errors++; $display("FAIL load_no_err: got %0d want 0", err_log.size()); end
  endtask

  task automatic test_prefix();
    clear_logs();
    send_byte(8'h41, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (wr_log.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL prefix_ignored: got writes %0d busy %b want 0 0", wr_log.size(), busy); end
    fill_random();
    send_frame();
    checks++; if (wr_log.size() !== DataLen) begin errors++; $display("FAIL prefix_wr_count: got %0d want %0d", wr_log.size(), DataLen); end
    for (int k = 0; k < DataLen && k < wr_log.size(); k++) begin
      checks++;
      if (wr_log[k].addr !== 10'(k) || wr_log[k].data !== exp_words[k]) begin
        errors++;
        $display("FAIL prefix_word%0d: got addr %0d data %h want addr %0d data %h", k, wr_log[k].addr, wr_log[k].data, k, exp_words[k]);
      end
    end
  endtask

  task automatic test_stop_err();
    clear_logs();
    fill_random();
    send_byte(8'h4C, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(fbytes[i], (i == 9) ? 1'b0 : 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (err_log.size() !== 1) begin errors++; $display("FAIL stoperr_pulse: got %0d want 1", err_log.size()); end
    checks++; if (wr_log.size() !== 1) begin errors++; $display("FAIL stoperr_wr_count: got %0d want 1", wr_log.size()); end
    if (wr_log.size() > 0) begin
      checks++;
      if (wr_log[0].addr !== 10'd0 || wr_log[0].data !== exp_words[0]) begin
        errors++; $display("FAIL stoperr_word0: got addr %0d data %h want addr 0 data %h", wr_log[0].addr, wr_log[0].data, exp_words[0]);
      end
    end
    checks++; if (busy !== 1'b0 || done_log.size() !== 0 || busy_overlap !== 0) begin
      errors++; $display("FAIL stoperr_idle: got busy %b done %0d overlap %0d want 0 0 0", busy, done_log.size(), busy_overlap);
    end
    clear_logs();
    fill_random();
    send_frame();
    checks++; if (wr_log.size() !== DataLen) begin errors++; $display("FAIL stoperr_next_count: got %0d want %0d", wr_log.size(), DataLen); end
    for (int k = 0; k < DataLen && k < wr_log.size(); k++) begin
      checks++;
      if (wr_log[k].addr !== 10'(k) || wr_log[k].data !== exp_words[k]) begin
        errors++;
        $display("FAIL stoperr_next_word%0d: got addr %0d data %h want addr %0d data %h", k, wr_log[k].addr, wr_log[k].data, k, exp_words[k]);
      end
    end
  endtask

  task automatic test_glitch();
    int act0;
    clear_logs();
    act0 = activity;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (activity !== act0) begin errors++; $display("FAIL glitch_quiet: got %0d active cycles want 0", activity - act0); end
    // A frame right after the glitch only loads if the receiver rejected it.
    fill_random();
    send_frame();
    checks++; if (wr_log.size() !== DataLen) begin errors++; $display("FAIL glitch_next_count: got %0d want %0d", wr_log.size(), DataLen); end
    for (int k = 0; k < DataLen && k < wr_log.size(); k++) begin
      checks++;
      if (wr_log[k].addr !== 10'(k) || wr_log[k].data !== exp_words[k]) begin
        errors++;
        $display("FAIL glitch_word%0d: got addr %0d data %h want addr %0d data %h", k, wr_log[k].addr, wr_log[k].data, k, exp_words[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    fill_random();
    send_byte(8'h4C, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(fbytes[i], 1'b1);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({wr_en, busy, load_done, frame_err, wr_addr, wr_data} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got en %b busy %b done %b err %b addr %0d data %h want all 0", wr_en, busy, load_done, frame_err, wr_addr, wr_data);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (wr_log.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_write: got writes %0d busy %b want 0 0", wr_log.size(), busy); end
    fill_random();
    send_frame();
    checks++; if (wr_log.size() !== DataLen) begin errors++; $display("FAIL rstmid_next_count: got %0d want %0d", wr_log.size(), DataLen); end
    for (int k = 0; k < DataLen && k < wr_log.size(); k++) begin
      checks++;
      if (wr_log[k].addr !== 10'(k) || wr_log[k].data !== exp_words[k]) begin
        errors++;
        $display("FAIL rstmid_word%0d: got addr %0d data %h want addr %0d data %h", k, wr_log[k].addr, wr_log[k].data, k, exp_words[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_all[2*DataLen];
    clear_logs();
    for (int f = 0; f < 2; f++) begin
      fill_random();
      for (int k = 0; k < DataLen; k++) exp_all[f*DataLen+k] = exp_words[k];
      send_byte(8'h4C, 1'b1);
      for (int i = 0; i < FrameBytes; i++) send_byte(fbytes[i], 1'b1);
    end
    repeat (10) @(negedge clk);
    checks++; if (wr_log.size() !== 2 * DataLen) begin errors++; $display("FAIL b2b_wr_count: got %0d want %0d", wr_log.size(), 2 * DataLen); end
    checks++; if (done_log.size() !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_log.size()); end
    for (int k = 0; k < 2 * DataLen && k < wr_log.size(); k++) begin
      checks++;
      if (wr_log[k].addr !== 10'(k % DataLen) || wr_log[k].data !== exp_all[k]) begin
        errors++;
        $display("FAIL b2b_word%0d: got addr %0d data %h want addr %0d data %h", k, wr_log[k].addr, wr_log[k].data, k % DataLen, exp_all[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int t_end;
    clear_logs();
    fill_random();
    send_byte(8'h4C, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(fbytes[i], 1'b1);
    t_end = cyc;
    repeat (300) @(negedge clk);
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL timeout_no_write: got %0d want 0", wr_log.size()); end
`ifdef LOADER_TIMEOUT_EN
    checks++; if (err_log.size() !== 1) begin errors++; $display("FAIL timeout_err_count: got %0d want 1", err_log.size()); end
    if (err_log.size() > 0) begin
      checks++;
      if (err_log[0] - t_end < 180 || err_log[0] - t_end > 215) begin
        errors++; $display("FAIL timeout_err_time: got %0d cycles after last byte want about 200", err_log[0] - t_end);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
`else
    checks++; if (err_log.size() !== 0) begin errors++; $display("FAIL stall_no_err: got %0d want 0", err_log.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    test_reset();
    test_load();
    test_prefix();
    test_stop_err();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
